// File: rtl/full_adder_bist.sv
// Built-in self-test engine for a one-bit full adder: sweeps all eight
// {a,b,cin} vectors, waits a programmable settle time per vector, checks
// sum/cout against the truth table and reports pass, error count and the
// first failing vector.
module full_adder_bist #(
  parameter int unsigned SETTLE_CYCLES = 1  // 1..255, cycles per vector before sampling
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       fa_a,
  output logic       fa_b,
  output logic       fa_cin,
  input  logic       fa_sum,
  input  logic       fa_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] vec, vec_nxt;
  logic [7:0] settle, settle_nxt;
  logic [3:0] err_nxt;
  logic       fev_nxt;
  logic [2:0] fvec_nxt;
  logic       pass_q, pass_nxt;

  logic       exp_sum, exp_cout, mismatch;

  // Golden truth table for the vector currently driven.
  always_comb begin
    exp_sum  = vec[2] ^ vec[1] ^ vec[0];
    exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    // Case inequality so an X/Z response from the adder counts as a failure.
    mismatch = (fa_sum !== exp_sum) || (fa_cout !== exp_cout);
  end

  // Next-state and result bookkeeping for the sweep.
  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    settle_nxt = settle;
    err_nxt    = err_count;
    fev_nxt    = first_err_valid;
    fvec_nxt   = first_err_vec;
    pass_nxt   = pass_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_WAIT;
          vec_nxt    = 3'd0;
          settle_nxt = SETTLE_LD;
          err_nxt    = 4'd0;
          fev_nxt    = 1'b0;
          fvec_nxt   = 3'd0;
          pass_nxt   = 1'b0;
        end
      end
      S_WAIT: begin
        // Counter is loaded with SETTLE_CYCLES, so WAIT spans exactly that many cycles.
        settle_nxt = settle - 8'd1;
        if (settle <= 8'd1) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_nxt = err_count + 4'd1;  // at most 8 checks per sweep, never wraps
          if (!first_err_valid) begin
            fev_nxt  = 1'b1;
            fvec_nxt = vec;
          end
        end
        if (vec == 3'd7) begin
          state_nxt = S_DONE;
        end else begin
          vec_nxt    = vec + 3'd1;
          settle_nxt = SETTLE_LD;
          state_nxt  = S_WAIT;
        end
      end
      S_DONE: begin
        pass_nxt  = (err_count == 4'd0);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= 3'd0;
      settle          <= 8'd0;
      err_count       <= 4'd0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'd0;
      pass_q          <= 1'b0;
    end else begin
      state           <= state_nxt;
      vec             <= vec_nxt;
      settle          <= settle_nxt;
      err_count       <= err_nxt;
      first_err_valid <= fev_nxt;
      first_err_vec   <= fvec_nxt;
      pass_q          <= pass_nxt;
    end
  end

  // Stimulus comes straight from the vector register; status decodes state.
  // pass is presented alongside done and then held by pass_q until the next start.
  always_comb begin
    fa_a   = vec[2];
    fa_b   = vec[1];
    fa_cin = vec[0];
    busy   = (state == S_WAIT) || (state == S_CHECK);
    done   = (state == S_DONE);
    pass   = (state == S_DONE) ? (err_count == 4'd0) : pass_q;
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// Randomized self-checking bench: two BIST instances (settle 1 and 3) each
// drive a behavioural full-adder model with injectable faults; expected
// results come from plain arithmetic over the eight vectors.
module tb_full_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3;
  logic a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
  logic a3, b3, c3, s3, co3, busy3, done3, pass3, fv3;
  logic [3:0] ec1, ec3;
  logic [2:0] fe1, fe3;

  // Fault configuration: 0 = per-vector flip mask, 1 = cout stuck 0, 2 = sum inverted
  int mode = 0;
  logic [7:0][1:0] kind = '0;  // bit0 flips sum, bit1 flips cout
  int sel = 0;                 // 0 -> settle-1 instance, 1 -> settle-3 instance

  int checks = 0;
  int failures = 0;

  full_adder_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .fa_a(a1), .fa_b(b1), .fa_cin(c1), .fa_sum(s1), .fa_cout(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err_valid(fv1), .first_err_vec(fe1));

  full_adder_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .fa_a(a3), .fa_b(b3), .fa_cin(c3), .fa_sum(s3), .fa_cout(co3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3),
    .first_err_valid(fv3), .first_err_vec(fe3));

  function automatic logic [1:0] fa_model(input int md, input logic [7:0][1:0] kd,
                                          input logic [2:0] v);
    logic [1:0] r;
    r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);  // {cout,sum}
    case (md)
      1:       r[1] = 1'b0;
      2:       r[0] = ~r[0];
      default: r = r ^ {kd[v][1], kd[v][0]};
    endcase
    return r;
  endfunction

  always_comb {co1, s1} = fa_model(mode, kind, {a1, b1, c1});
  always_comb {co3, s3} = fa_model(mode, kind, {a3, b3, c3});

  // Does the adder model give a wrong answer for vector v?
  function automatic bit exp_fail(input int v);
    int ones;
    ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    case (mode)
      1:       return ones >= 2;
      2:       return 1'b1;
      default: return kind[v] != 2'b00;
    endcase
  endfunction

  logic m_a, m_b, m_c, m_busy, m_done, m_pass, m_fv;
  logic [3:0] m_ec;
  logic [2:0] m_fe;
  always_comb begin
    if (sel == 0) begin
      m_a = a1; m_b = b1; m_c = c1; m_busy = busy1; m_done = done1;
      m_pass = pass1; m_fv = fv1; m_ec = ec1; m_fe = fe1;
    end else begin
      m_a = a3; m_b = b3; m_c = c3; m_busy = busy3; m_done = done3;
      m_pass = pass3; m_fv = fv3; m_ec = ec3; m_fe = fe3;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start1 = v; else start3 = v;
  endtask

  // Raise start for the selected instance; the following posedge is edge 0.
  task automatic launch(input bit hold);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(1'b0);
  endtask

  // Follows one sweep from edge 0 until done, checking every cycle's vector,
  // busy and running error count, then the final results. poke toggles start
  // randomly mid-run.
  task automatic monitor(input string tag, input bit poke);
    int s, lim, c, dc, ev, ne, bv, bb, be, et, ef;
    s  = (sel == 0) ? 1 : 3;
    lim = 8 * (s + 1) + 1;
    c = 0; dc = -1; bv = 0; bb = 0; be = 0;
    while (dc < 0 && c < lim + 4) begin
      @(negedge clk);
      c++;
      if (poke) set_start((c < lim - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      ev = (c - 1) / (s + 1);
      if (ev > 7) ev = 7;
      if ({m_a, m_b, m_c} != 3'(ev)) bv++;
      if (m_busy != (c <= 8 * (s + 1))) bb++;
      ne = 0;
      for (int n = 0; n < 8; n++) if (exp_fail(n) && (n + 1) * (s + 1) < c) ne++;
      if (int'(m_ec) != ne) be++;
      if (m_done) dc = c;
    end
    et = 0; ef = -1;
    for (int n = 0; n < 8; n++) if (exp_fail(n)) begin et++; if (ef < 0) ef = n; end
    chk({tag, "_done_cyc"}, dc, lim);
    chk({tag, "_vec_trace"}, bv, 0);
    chk({tag, "_busy_trace"}, bb, 0);
    chk({tag, "_errc_trace"}, be, 0);
    chk({tag, "_pass"}, int'(m_pass), int'(et == 0));
    chk({tag, "_err_count"}, int'(m_ec), et);
    chk({tag, "_fev_valid"}, int'(m_fv), int'(ef >= 0));
    chk({tag, "_fev_vec"}, int'(m_fe), (ef >= 0) ? ef : 0);
  endtask

  initial begin
    int dn, bz;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fa", int'({a1, b1, c1}), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_errc", int'(ec1), 0);
    chk("rst_fev", int'({fv1, fe1}), 0);
    chk("rst_busy3", int'(busy3), 0);

    // Correct adder, settle 1
    sel = 0; mode = 0; kind = '0;
    launch(0); monitor("good1", 0);
    @(negedge clk);
    chk("good1_pass_held", int'(pass1), 1);
    chk("good1_fa_held", int'({a1, b1, c1}), 7);

    // cout stuck at 0, then sum inverted, then correct again (clear on start)
    mode = 1; launch(0); monitor("cout0", 0);
    @(negedge clk);
    chk("cout0_pass_held", int'(pass1), 0);
    mode = 2; launch(0); monitor("suminv", 0);
    mode = 0; kind = '0; launch(0); monitor("reclear", 0);

    // Settle 3: CHECK timing shows through the running error count
    sel = 1; mode = 2; launch(0); monitor("s3_suminv", 0);
    mode = 0; launch(0); monitor("s3_good", 0);

    // Random per-vector fault masks on both instances
    for (int r = 0; r < 8; r++) begin
      sel = r % 2;
      mode = 0;
      for (int v = 0; v < 8; v++)
        kind[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      launch(0); monitor($sformatf("rnd%0d", r), (r % 3) == 0);
    end

    // Reset during the WAIT for vec=100 discards the partial run
    sel = 0; mode = 2;
    launch(0);
    repeat (9) @(negedge clk);
    chk("pre_rst_errc", int'(ec1), 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_fa", int'({a1, b1, c1}), 0);
    chk("mid_rst_status", int'({busy1, done1, pass1}), 0);
    chk("mid_rst_errc", int'(ec1), 0);
    chk("mid_rst_fev", int'({fv1, fe1}), 0);
    rst = 1'b0;
    dn = 0; bz = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1) dn++;
      if (busy1) bz++;
    end
    chk("post_rst_no_done", dn, 0);
    chk("post_rst_no_busy", bz, 0);
    mode = 0; kind = '0;
    launch(0); monitor("after_rst", 0);

    // start held high across DONE: restart after exactly one IDLE cycle
    sel = 0; mode = 1;
    launch(1); monitor("hold_a", 0);
    @(negedge clk);
    chk("hold_idle_busy", int'(busy1), 0);
    chk("hold_idle_done", int'(done1), 0);
    @(posedge clk);
    #1 set_start(1'b0);
    monitor("hold_b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
